// File: rtl/regfile_wb_queue.sv
// regfile_wb_queue: in-order writeback FIFO in front of the register file
// write port (We/A3/WD). Drains one entry per cycle unless the register file
// stalls. It can also forward the youngest pending write to read ports A1/A2.
// Optional feature macro: WBQ_FORWARD_EN
//   defined   -> forwarding lookup for A1/A2 is built
//   undefined -> fwd_hit*/fwd_data* are tied to 0 and no comparators exist
module regfile_wb_queue #(
  parameter int DEPTH = 4,
  parameter int AW = 5,
  parameter int DW = 32,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          enq_valid,
  output logic          enq_ready,
  input  logic [AW-1:0] enq_addr,
  input  logic [DW-1:0] enq_data,
  input  logic          wr_stall,
  output logic          We,
  output logic [AW-1:0] A3,
  output logic [DW-1:0] WD,
  input  logic [AW-1:0] A1,
  input  logic [AW-1:0] A2,
  output logic          fwd_hit1,
  output logic [DW-1:0] fwd_data1,
  output logic          fwd_hit2,
  output logic [DW-1:0] fwd_data2,
  output logic [CW-1:0] count
);

  logic [PW-1:0]    head_reg;
  logic [PW-1:0]    tail_reg;
  logic [CW-1:0]    count_reg;
  logic [DEPTH-1:0] valid_reg;
  logic [DEPTH-1:0] valid_next;
  logic [AW-1:0]    addr_mem [DEPTH];
  logic [DW-1:0]    data_mem [DEPTH];

  logic not_empty;
  logic enq_fire;
  logic enq_store;

  assign not_empty = (count_reg != '0);
  assign We        = not_empty & ~wr_stall & ~flush;
  // A full queue still accepts when the head drains in the same cycle.
  assign enq_ready = ~flush & ((count_reg < CW'(DEPTH)) | We);
  assign enq_fire  = enq_valid & enq_ready;
  // Writes to x0 complete the handshake but are never stored.
  assign enq_store = enq_fire & (enq_addr != '0);

  assign A3    = not_empty ? addr_mem[head_reg] : '0;
  assign WD    = not_empty ? data_mem[head_reg] : '0;
  assign count = count_reg;

  // Pointer and occupancy tracking; flush empties the queue at the next edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else if (flush) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else begin
      if (We) head_reg <= head_reg + PW'(1);
      if (enq_store) tail_reg <= tail_reg + PW'(1);
      case ({enq_store, We})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Per-entry valid bits; a slot refilled as it drains (full queue) stays valid.
  always_comb begin
    valid_next = valid_reg;
    if (We) valid_next[head_reg] = 1'b0;
    if (enq_store) valid_next[tail_reg] = 1'b1;
  end

  // Valid bit register, cleared by reset or flush.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_reg <= '0;
    end else if (flush) begin
      valid_reg <= '0;
    end else begin
      valid_reg <= valid_next;
    end
  end

  // Entry storage written at the tail on a stored enqueue.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        addr_mem[i] <= '0;
        data_mem[i] <= '0;
      end
    end else if (enq_store) begin
      addr_mem[tail_reg] <= enq_addr;
      data_mem[tail_reg] <= enq_data;
    end
  end

`ifdef WBQ_FORWARD_EN
  logic [PW-1:0] idx;

  // Scan from head (oldest) to youngest so the last match wins.
  always_comb begin
    fwd_hit1  = 1'b0;
    fwd_data1 = '0;
    fwd_hit2  = 1'b0;
    fwd_data2 = '0;
    idx       = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head_reg + PW'(k);
      if (valid_reg[idx] && (A1 != '0) && (addr_mem[idx] == A1)) begin
        fwd_hit1  = 1'b1;
        fwd_data1 = data_mem[idx];
      end
      if (valid_reg[idx] && (A2 != '0) && (addr_mem[idx] == A2)) begin
        fwd_hit2  = 1'b1;
        fwd_data2 = data_mem[idx];
      end
    end
  end
`else
  logic unused_fwd;

  assign unused_fwd = ^{A1, A2, valid_reg};
  assign fwd_hit1   = 1'b0;
  assign fwd_data1  = '0;
  assign fwd_hit2   = 1'b0;
  assign fwd_data2  = '0;
`endif

endmodule

// File: tb/tb_regfile_wb_queue.sv
// tb_regfile_wb_queue: randomized scoreboard bench for regfile_wb_queue.
// The stimulus process models the queue as a plain list of pending writes;
// a separate monitor pops expected register-file writes whenever We is seen.
module tb_regfile_wb_queue;
  localparam int DEPTH = 4;
  localparam int AW = 5;
  localparam int DW = 32;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam bit FWD_EN =
`ifdef WBQ_FORWARD_EN
    1'b1;
`else
    1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          flush = 1'b0;
  logic          enq_valid = 1'b0;
  logic          wr_stall = 1'b0;
  logic [AW-1:0] enq_addr = '0;
  logic [AW-1:0] A1 = '0;
  logic [AW-1:0] A2 = '0;
  logic [DW-1:0] enq_data = '0;
  logic          enq_ready, We, fwd_hit1, fwd_hit2;
  logic [AW-1:0] A3;
  logic [DW-1:0] WD, fwd_data1, fwd_data2;
  logic [CW-1:0] count;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } ent_t;

  ent_t model_q[$];
  ent_t sb_q[$];
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  regfile_wb_queue #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .enq_valid(enq_valid), .enq_ready(enq_ready),
    .enq_addr(enq_addr), .enq_data(enq_data),
    .wr_stall(wr_stall), .We(We), .A3(A3), .WD(WD),
    .A1(A1), .A2(A2),
    .fwd_hit1(fwd_hit1), .fwd_data1(fwd_data1),
    .fwd_hit2(fwd_hit2), .fwd_data2(fwd_data2),
    .count(count)
  );

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  // Youngest pending write to address a, from the list of pending writes.
  function automatic void model_fwd(input logic [AW-1:0] a, output logic hit,
                                    output logic [DW-1:0] data);
    hit  = 1'b0;
    data = '0;
    if (FWD_EN && a != '0) begin
      foreach (model_q[i]) begin
        if (model_q[i].a == a) begin
          hit  = 1'b1;
          data = model_q[i].d;
        end
      end
    end
  endfunction

  // One clock cycle: drive, check combinational outputs, advance the model.
  task automatic step(input logic ev, input logic [AW-1:0] ea, input logic [DW-1:0] ed,
                      input logic st, input logic fl,
                      input logic [AW-1:0] a1, input logic [AW-1:0] a2);
    int            sz;
    logic          ew, er, h1, h2;
    logic [DW-1:0] d1, d2;
    @(posedge clk);
    #1;
    enq_valid = ev; enq_addr = ea; enq_data = ed;
    wr_stall = st; flush = fl; A1 = a1; A2 = a2;
    sz = model_q.size();
    ew = (sz != 0) && !st && !fl;
    er = !fl && ((sz < DEPTH) || ew);
    if (fl) sb_q.delete();
    else if (ev && er && ea != '0) sb_q.push_back({ea, ed});
    #1;
    model_fwd(a1, h1, d1);
    model_fwd(a2, h2, d2);
    chk("count", 64'(count), 64'(sz));
    chk("enq_ready", 64'(enq_ready), 64'(er));
    chk("we", 64'(We), 64'(ew));
    chk("fwd_hit1", 64'(fwd_hit1), 64'(h1));
    chk("fwd_data1", 64'(fwd_data1), 64'(d1));
    chk("fwd_hit2", 64'(fwd_hit2), 64'(h2));
    chk("fwd_data2", 64'(fwd_data2), 64'(d2));
    if (sz == 0) begin
      chk("a3_empty", 64'(A3), 64'(0));
      chk("wd_empty", 64'(WD), 64'(0));
    end
    if (ev && er) $display("enq addr=%0d data=%08h count=%0d", ea, ed, sz);
    if (fl) begin
      $display("flush dropped=%0d", sz);
      model_q.delete();
    end else begin
      if (ew) void'(model_q.pop_front());
      if (ev && er && ea != '0) model_q.push_back({ea, ed});
    end
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
  endtask

  // Asynchronous reset asserted and released away from any clock edge.
  task automatic async_reset();
    @(posedge clk);
    #3;
    rst = 1'b0;
    enq_valid = 1'b0; flush = 1'b0; wr_stall = 1'b0;
    #1;
    chk("rst_we", 64'(We), 64'(0));
    chk("rst_a3", 64'(A3), 64'(0));
    chk("rst_wd", 64'(WD), 64'(0));
    chk("rst_count", 64'(count), 64'(0));
    chk("rst_ready", 64'(enq_ready), 64'(1));
    $display("async reset dropped=%0d", model_q.size());
    model_q.delete();
    sb_q.delete();
    @(negedge clk);
    #2;
    rst = 1'b1;
  endtask

  // Monitor: every register-file write must match the oldest expected write.
  initial begin
    ent_t e;
    forever begin
      @(negedge clk);
      if (rst === 1'b1 && We === 1'b1) begin
        if (sb_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_write: got a3=%0d wd=%08h required no write", A3, WD);
        end else begin
          e = sb_q.pop_front();
          chk("wr_addr", 64'(A3), 64'(e.a));
          chk("wr_data", 64'(WD), 64'(e.d));
          $display("write a3=%0d wd=%08h", A3, WD);
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #1;
    chk("reset_count", 64'(count), 64'(0));
    chk("reset_we", 64'(We), 64'(0));
    chk("reset_a3", 64'(A3), 64'(0));
    chk("reset_wd", 64'(WD), 64'(0));
    chk("reset_ready", 64'(enq_ready), 64'(1));
    chk("reset_fwd", 64'({fwd_hit1, fwd_hit2, fwd_data1, fwd_data2}), 64'(0));
    #11;
    rst = 1'b1;

    // single write, one-cycle enqueue-to-write
    step(1'b1, 5'd3, 32'hDEADBEEF, 1'b0, 1'b0, '0, '0);
    idle(2);

    // fill while stalled, fifth request waits, accepted on first drain
    for (int i = 1; i <= 4; i++)
      step(1'b1, AW'(i), DW'(i * 32'h11), 1'b1, 1'b0, '0, '0);
    step(1'b1, 5'd5, 32'h55, 1'b1, 1'b0, '0, '0);
    step(1'b1, 5'd5, 32'h55, 1'b0, 1'b0, '0, '0);
    idle(6);

    // forwarding picks youngest, x0 never stored
    step(1'b1, 5'd5, 32'hA, 1'b1, 1'b0, '0, '0);
    step(1'b1, 5'd5, 32'hB, 1'b1, 1'b0, '0, '0);
    step(1'b1, 5'd0, 32'hC, 1'b1, 1'b0, '0, '0);
    step(1'b0, '0, '0, 1'b1, 1'b0, 5'd5, 5'd0);
    idle(4);

    // flush with three entries pending and a request present
    for (int i = 0; i < 3; i++)
      step(1'b1, AW'(i + 8), DW'(32'h100 + i), 1'b1, 1'b0, 5'd8, 5'd9);
    step(1'b1, 5'd7, 32'h77, 1'b1, 1'b1, 5'd8, 5'd10);
    idle(3);

    // async reset mid-drain with entries still pending
    for (int i = 0; i < 3; i++)
      step(1'b1, AW'(i + 12), DW'(32'h200 + i), 1'b1, 1'b0, '0, '0);
    step(1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
    async_reset();
    idle(4);

    // randomized traffic
    for (int n = 0; n < 500; n++) begin
      if ($urandom_range(0, 149) == 0) begin
        async_reset();
      end else begin
        step(1'($urandom_range(0, 2) != 0), AW'($urandom_range(0, 7)), $urandom,
             1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 24) == 0),
             AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)));
      end
    end

    idle(DEPTH + 2);
    @(negedge clk);
    #1;
    chk("drain_empty", 64'(sb_q.size()), 64'(0));
    chk("final_count", 64'(count), 64'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
